dm_access_ctrl: RTL and testbench

Data-memory access sequencer sitting between the EX/MEM pipeline register and a multi-cycle data memory. It launches each load/store held in EX/MEM as a request/ready transaction, returns load data, and drives `EX_MEM_reg_disable_stall` back to the hazard control unit. While an access is outstanding that signal holds the whole pipeline; it drops for exactly one cycle when the access completes.

---
 rtl/dm_ctrl_pkg.sv | 19 +
 rtl/dm_timeout_cnt.sv | 30 +++
 rtl/dm_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_dm_access_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared types, default widths and helpers for the data-memory access sequencer.
package dm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dm_state_e;

  localparam int unsigned DM_ADDR_W         = 32;
  localparam int unsigned DM_DATA_W         = 32;
  localparam int unsigned DM_TIMEOUT_CYCLES = 255;

  function automatic int unsigned strb_width(input int unsigned data_w);
    return data_w / 32'd8;
  endfunction

endpackage

// File: rtl/dm_timeout_cnt.sv
// Per-access wait counter; expired flags the cycle whose increment reaches the limit.
module dm_timeout_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Wait-cycle counter, restarted at each phase of an access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign expired = enable && ((count + CNT_W'(1)) == limit);

endmodule

// File: rtl/dm_access_ctrl.sv
// Sequences EX/MEM loads/stores onto a request/ready data memory and stalls the pipeline meanwhile.
// Optional watchdog enabled by defining DM_TIMEOUT_EN.
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter  int unsigned ADDR_W         = DM_ADDR_W,
  parameter  int unsigned DATA_W         = DM_DATA_W,
  parameter  int unsigned TIMEOUT_CYCLES = DM_TIMEOUT_CYCLES,
  localparam int unsigned STRB_W         = strb_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MEM_mem_r,
  input  logic              EX_MEM_mem_w,
  input  logic              EX_MEM_flush,
  input  logic [ADDR_W-1:0] EX_MEM_addr,
  input  logic [DATA_W-1:0] EX_MEM_wdata,
  input  logic [STRB_W-1:0] EX_MEM_wstrb,
  output logic              EX_MEM_reg_disable_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [STRB_W-1:0] dm_wstrb,
  input  logic              dm_ready,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err
);

  dm_state_e state;
  dm_state_e state_next;
  logic      start;
  logic      timeout_hit;
  logic      timeout_expired;

  // A flush in IDLE kills the access before it is launched
  assign start = (EX_MEM_mem_r | EX_MEM_mem_w) & ~EX_MEM_flush;

`ifdef DM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  dm_timeout_cnt #(.CNT_W(CNT_W)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == ST_IDLE && start) || (state == ST_REQ && dm_ready)),
    .enable (state == ST_REQ || state == ST_WAIT),
    .limit  (CNT_W'(TIMEOUT_CYCLES)),
    .expired(timeout_expired)
  );
`else
  // Without the watchdog an access waits for the memory indefinitely
  assign timeout_expired = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a real handshake wins over a simultaneous watchdog expiry
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_REQ;
        else       state_next = ST_IDLE;
      end
      ST_REQ: begin
        if (dm_ready) begin
          state_next = dm_we ? ST_DONE : ST_WAIT;
        end else if (timeout_expired) begin
          state_next  = ST_DONE;
          timeout_hit = 1'b1;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dm_rvalid) begin
          state_next = ST_DONE;
        end else if (timeout_expired) begin
          state_next  = ST_DONE;
          timeout_hit = 1'b1;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Stall is combinational in IDLE so the hazard unit freezes the cycle the access arrives
  always_comb begin
    EX_MEM_reg_disable_stall = 1'b0;
    if (rst) begin
      EX_MEM_reg_disable_stall = 1'b0;
    end else begin
      case (state)
        ST_IDLE:          EX_MEM_reg_disable_stall = start;
        ST_REQ, ST_WAIT:  EX_MEM_reg_disable_stall = 1'b1;
        ST_DONE:          EX_MEM_reg_disable_stall = 1'b0;
        default:          EX_MEM_reg_disable_stall = 1'b0;
      endcase
    end
  end

  // Registered memory request, load return and error outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      dm_wstrb   <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      dm_err     <= 1'b0;
    end else begin
      dm_req     <= (state_next == ST_REQ);
      load_valid <= (state_next == ST_DONE) && !dm_we;
      dm_err     <= timeout_hit;
      if (state == ST_IDLE && start) begin
        dm_we    <= ~EX_MEM_mem_r;
        dm_addr  <= EX_MEM_addr;
        dm_wdata <= EX_MEM_wdata;
        dm_wstrb <= EX_MEM_wstrb;
      end
      if (state == ST_WAIT && dm_rvalid) begin
        load_data <= dm_rdata;
      end else if (timeout_hit && !dm_we) begin
        load_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl; a memory model reacts to dm_req with programmed latencies.
// Define DM_TIMEOUT_EN to also exercise the watchdog with an 8-cycle limit.
module tb_dm_access_ctrl;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst;
  logic        mem_r, mem_w, flush;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_ready, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;

  int errors = 0;
  int checks = 0;

  dm_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .EX_MEM_mem_r(mem_r), .EX_MEM_mem_w(mem_w), .EX_MEM_flush(flush),
    .EX_MEM_addr(addr), .EX_MEM_wdata(wdata), .EX_MEM_wstrb(wstrb),
    .EX_MEM_reg_disable_stall(stall),
    .load_data(load_data), .load_valid(load_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dm_err(dm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // Drives one access until the bench-predicted DONE cycle; memory answers after the given waits.
  task automatic access(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input int rdy_wait, input int rv_wait,
                        input logic [31:0] rdata, input int flush_cyc,
                        output int stall_hi, output int stall_lo, output int lv_cnt,
                        output logic [31:0] ld, output bit first_stall,
                        output bit fields_ok, output bit done);
    int  req_cnt = 0;
    int  wait_cnt = 0;
    bit  waiting = 1'b0;
    bit  finishing = 1'b0;
    stall_hi = 0; stall_lo = 0; lv_cnt = 0; ld = 32'h0;
    first_stall = 1'b0; fields_ok = 1'b1; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      mem_r = rd; mem_w = !rd; addr = a; wdata = wd; wstrb = ws;
      flush = (c == flush_cyc);
      dm_ready  = dm_req && (req_cnt == rdy_wait);
      dm_rvalid = waiting && (wait_cnt == rv_wait);
      dm_rdata  = dm_rvalid ? rdata : 32'hBAD0_BAD0;
      #1;
      if (c == 0) first_stall = stall;
      if (stall) stall_hi++; else stall_lo++;
      if (load_valid) begin lv_cnt++; ld = load_data; end
      if (dm_req && (dm_addr !== a || dm_we !== !rd ||
                     (!rd && (dm_wdata !== wd || dm_wstrb !== ws)))) fields_ok = 1'b0;
      if (finishing) done = 1'b1;
      if (dm_req) req_cnt++;
      if (waiting) wait_cnt++;
      if (dm_ready) begin
        if (rd) waiting = 1'b1; else finishing = 1'b1;
      end
      if (dm_rvalid) begin waiting = 1'b0; finishing = 1'b1; end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_r = 1'b0; mem_w = 1'b0; flush = 1'b0; dm_ready = 1'b0; dm_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_r = 1'b0; mem_w = 1'b0; flush = 1'b0; addr = 32'h0; wdata = 32'h0;
    wstrb = 4'h0; dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    repeat (2) @(negedge clk);
    mem_r = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if ({dm_req, dm_we, load_valid, dm_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {dm_req, dm_we, load_valid, dm_err}); end
    checks++; if ({dm_addr, dm_wdata, dm_wstrb, load_data} !== 100'h0) begin
      errors++; $display("FAIL reset_fields: got %h %h %h %h expected all zero", dm_addr, dm_wdata, dm_wstrb, load_data); end
    @(negedge clk);
    rst = 1'b0; mem_r = 1'b0;
  endtask

  task automatic test_read();
    int sh, sl, lv; logic [31:0] ld; bit fs, fok, dn;
    access(1'b1, 32'h100, 32'h0, 4'h0, 1, 2, 32'hDEAD_BEEF, -1, sh, sl, lv, ld, fs, fok, dn);
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL read_done: got %b expected 1", dn); end
    checks++; if (sh != 6) begin errors++; $display("FAIL read_stall_cycles: got %0d expected 6", sh); end
    checks++; if (lv != 1) begin errors++; $display("FAIL read_valid_pulses: got %0d expected 1", lv); end
    checks++; if (ld !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", ld); end
    checks++; if (fok !== 1'b1) begin errors++; $display("FAIL read_fields: got %b expected 1", fok); end
    idle_cycle();
  endtask

  task automatic test_write();
    int sh, sl, lv; logic [31:0] ld; bit fs, fok, dn;
    access(1'b0, 32'h104, 32'h1234_5678, 4'h3, 0, 0, 32'h0, -1, sh, sl, lv, ld, fs, fok, dn);
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL write_done: got %b expected 1", dn); end
    checks++; if (sh != 2) begin errors++; $display("FAIL write_stall_cycles: got %0d expected 2", sh); end
    checks++; if (lv != 0) begin errors++; $display("FAIL write_no_load_valid: got %0d expected 0", lv); end
    checks++; if (fok !== 1'b1) begin errors++; $display("FAIL write_fields: got %b expected 1", fok); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int sh1, sl1, lv1, sh2, sl2, lv2; logic [31:0] ld1, ld2; bit fs1, fok1, dn1, fs2, fok2, dn2;
    access(1'b1, 32'h200, 32'h0, 4'h0, 0, 0, 32'hA5A5_0001, -1, sh1, sl1, lv1, ld1, fs1, fok1, dn1);
    access(1'b1, 32'h204, 32'h0, 4'h0, 0, 0, 32'h5A5A_0002, -1, sh2, sl2, lv2, ld2, fs2, fok2, dn2);
    checks++; if (sh1 != 3 || sh2 != 3) begin errors++; $display("FAIL b2b_stall_cycles: got %0d,%0d expected 3,3", sh1, sh2); end
    checks++; if (sl1 != 1 || fs2 !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: got low=%0d next_start_stall=%b expected low=1 next_start_stall=1", sl1, fs2); end
    checks++; if (lv1 != 1 || lv2 != 1) begin errors++; $display("FAIL b2b_valid_pulses: got %0d,%0d expected 1,1", lv1, lv2); end
    checks++; if (ld1 !== 32'hA5A5_0001 || ld2 !== 32'h5A5A_0002) begin
      errors++; $display("FAIL b2b_data: got %h,%h expected a5a50001,5a5a0002", ld1, ld2); end
    checks++; if (fok2 !== 1'b1) begin errors++; $display("FAIL b2b_second_addr: got %b expected 1", fok2); end
  endtask

  task automatic test_rvalid_ignored();
    @(negedge clk);
    mem_r = 1'b0; mem_w = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dm_rvalid = 1'b0;
    #1;
    checks++; if (load_valid !== 1'b0 || load_data !== 32'h5A5A_0002) begin
      errors++; $display("FAIL stray_rvalid: got valid=%b data=%h expected valid=0 data=5a5a0002", load_valid, load_data); end
  endtask

  task automatic test_flush();
    int sh, sl, lv; logic [31:0] ld; bit fs, fok, dn;
    @(negedge clk);
    mem_r = 1'b1; flush = 1'b1; addr = 32'h300;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall: got %b expected 0", stall); end
    @(negedge clk);
    mem_r = 1'b0; flush = 1'b0;
    #1;
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL flush_start_req: got %b expected 0", dm_req); end
    // flush lands in the second WAIT cycle and must not abort the read
    access(1'b1, 32'h308, 32'h0, 4'h0, 0, 2, 32'hC0FF_EE00, 3, sh, sl, lv, ld, fs, fok, dn);
    checks++; if (sh != 5 || lv != 1 || ld !== 32'hC0FF_EE00) begin
      errors++; $display("FAIL flush_in_wait: got stall=%0d lv=%0d data=%h expected stall=5 lv=1 data=c0ffee00", sh, lv, ld); end
    idle_cycle();
    #1;
    checks++; if (stall !== 1'b0 || dm_req !== 1'b0) begin
      errors++; $display("FAIL flush_back_idle: got stall=%b req=%b expected 0 0", stall, dm_req); end
  endtask

  task automatic test_reset_mid();
    int sh, sl, lv; logic [31:0] ld; bit fs, fok, dn;
    @(negedge clk);
    mem_r = 1'b1; mem_w = 1'b0; addr = 32'h400; dm_ready = 1'b0; dm_rvalid = 1'b0;
    @(negedge clk);
    dm_ready = 1'b1;
    @(negedge clk);
    dm_ready = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_wait_stall: got %b expected 1", stall); end
    rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || dm_req !== 1'b0 || load_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_drop: got stall=%b req=%b lv=%b expected 0 0 0", stall, dm_req, load_valid); end
    @(negedge clk);
    rst = 1'b0; mem_r = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h7777_7777;
    @(negedge clk);
    dm_rvalid = 1'b0;
    #1;
    checks++; if (load_data !== 32'h0 || load_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_discard: got data=%h lv=%b expected 00000000 0", load_data, load_valid); end
    access(1'b1, 32'h404, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D, -1, sh, sl, lv, ld, fs, fok, dn);
    checks++; if (sh != 3 || lv != 1 || ld !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL mid_reset_recover: got stall=%0d lv=%0d data=%h expected 3 1 0badf00d", sh, lv, ld); end
    idle_cycle();
  endtask

`ifdef DM_TIMEOUT_EN
  task automatic test_timeout();
    int err_cyc = -1;
    logic lv_at_err = 1'b0;
    logic [31:0] ld_at_err = 32'hFFFF_FFFF;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      mem_r = (err_cyc < 0); mem_w = 1'b0; addr = 32'h500; dm_ready = 1'b0; flush = 1'b0;
      dm_rvalid = (c == 12);
      dm_rdata = 32'h1111_2222;
      #1;
      if (dm_err && err_cyc < 0) begin err_cyc = c; lv_at_err = load_valid; ld_at_err = load_data; end
    end
    checks++; if (err_cyc != 9) begin errors++; $display("FAIL timeout_cycle: got %0d expected 9", err_cyc); end
    checks++; if (lv_at_err !== 1'b1 || ld_at_err !== 32'h0) begin
      errors++; $display("FAIL timeout_load: got lv=%b data=%h expected 1 00000000", lv_at_err, ld_at_err); end
    checks++; if (stall !== 1'b0 || dm_req !== 1'b0 || load_data !== 32'h0) begin
      errors++; $display("FAIL timeout_idle: got stall=%b req=%b data=%h expected 0 0 00000000", stall, dm_req, load_data); end
    idle_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_rvalid_ignored();
    test_flush();
    test_reset_mid();
`ifdef DM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
